// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop input synchronizer, start-edge detection, mid-bit
// sampling, and a single-entry valid/ready output register with error pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       rx_clk,
  input  logic       rx_rst,
  input  logic       rx_input,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       rx_frame_err,
  output logic       rx_overrun,
  output logic       rx_busy
);

  localparam logic [15:0] HALF_CNT = 16'(CLKS_PER_BIT / 2 - 1);
  localparam logic [15:0] BIT_CNT  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state_q, state_d;
  logic        line_s1, line_s2, line_prev;
  logic        line_fall;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [7:0]  data_d;
  logic        valid_d, ferr_d, ovr_d;

  // line_prev tracks the synchronized line so a level held low never re-arms
  assign line_fall = line_prev & ~line_s2;
  assign rx_busy   = (state_q != IDLE);

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      line_s1      <= 1'b1;
      line_s2      <= 1'b1;
      line_prev    <= 1'b1;
      state_q      <= IDLE;
      cnt_q        <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      rx_frame_err <= 1'b0;
      rx_overrun   <= 1'b0;
    end else begin
      line_s1      <= rx_input;
      line_s2      <= line_s1;
      line_prev    <= line_s2;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      rx_data      <= data_d;
      rx_valid     <= valid_d;
      rx_frame_err <= ferr_d;
      rx_overrun   <= ovr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    data_d  = rx_data;
    valid_d = rx_valid & ~rx_ready;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (line_fall) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CNT) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = line_s2 ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d   = '0;
          shreg_d = {line_s2, shreg_q[7:1]};
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == BIT_CNT) begin
          cnt_d   = '0;
          state_d = IDLE;
          // a consume in the same cycle frees the slot for the new byte
          if (!line_s2) begin
            ferr_d = 1'b1;
          end else if (!rx_valid || rx_ready) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed frame table, multi-cycle corner sequences, and
// random frames scored against a byte-level receive model.
module tb_uart_rx;
  localparam int C = 434;
  localparam int L = C / 2 + 9 * C + 3;  // pin fall to rx_valid rise, nominal

  logic       rx_clk = 1'b0;
  logic       rx_rst = 1'b1;
  logic       rx_input = 1'b1;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, rx_frame_err, rx_overrun, rx_busy;

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .rx_clk(rx_clk), .rx_rst(rx_rst), .rx_input(rx_input),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun), .rx_busy(rx_busy)
  );

  always #5 rx_clk = ~rx_clk;

  int cyc = 0;
  always @(posedge rx_clk) cyc <= cyc + 1;

  // event monitor, sampled on the falling edge
  int   ferr_seen = 0, ovr_seen = 0, both_seen = 0, wide_seen = 0;
  int   rise_cnt = 0, fall_cnt = 0, rise_cyc = 0, vrun = 0, last_vw = 0;
  logic p_ferr = 1'b0, p_ovr = 1'b0, p_valid = 1'b0;
  always @(negedge rx_clk) begin
    if (rx_frame_err === 1'b1) ferr_seen <= ferr_seen + 1;
    if (rx_overrun === 1'b1) ovr_seen <= ovr_seen + 1;
    if (rx_frame_err === 1'b1 && rx_overrun === 1'b1) both_seen <= both_seen + 1;
    if ((rx_frame_err === 1'b1 && p_ferr) || (rx_overrun === 1'b1 && p_ovr))
      wide_seen <= wide_seen + 1;
    if (rx_valid === 1'b1 && !p_valid) begin
      rise_cnt <= rise_cnt + 1;
      rise_cyc <= cyc;
    end
    if (rx_valid !== 1'b1 && p_valid) begin
      fall_cnt <= fall_cnt + 1;
      last_vw  <= vrun;
    end
    vrun    <= (rx_valid === 1'b1) ? vrun + 1 : 0;
    p_ferr  <= (rx_frame_err === 1'b1);
    p_ovr   <= (rx_overrun === 1'b1);
    p_valid <= (rx_valid === 1'b1);
  end

  int vec_cnt = 0, bad_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge rx_clk);
  endtask

  // receive model: pending byte slot plus expected error totals
  logic [7:0] model_d = 8'h00;
  logic       model_v = 1'b0;
  int         model_fe = 0, model_ov = 0;
  int         fall_cyc = 0;

  task automatic pulse_ready();
    rx_ready = 1'b1;
    @(negedge rx_clk);
    rx_ready = 1'b0;
    @(negedge rx_clk);
    model_v = 1'b0;
  endtask

  // mode 0: ready low; 1: ready high all frame; 2: ready high only on the stop-sample cycle
  task automatic send_frame(input logic [7:0] d, input logic stop, input int mode,
                            input int rst_at, input int hold);
    int b;
    for (int i = 0; i < 10 * C; i++) begin
      b = i / C;
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_busy", 32'(rx_busy), 0);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_data", 32'(rx_data), 0);
        chk("rst_ferr", 32'(rx_frame_err), 0);
        chk("rst_ovr", 32'(rx_overrun), 0);
      end
      if (i == 0) fall_cyc = cyc;
      rx_input = (b == 0) ? 1'b0 : (b <= 8) ? d[b-1] : stop;
      if (rst_at >= 0 && i >= rst_at) rx_input = 1'b1;
      rx_rst   = (i == rst_at);
      rx_ready = (mode == 1) || (mode == 2 && i == L - 1);
      @(negedge rx_clk);
    end
    if (hold > 0) begin
      rx_input = 1'b0;
      idle(hold);
    end
    rx_input = 1'b1;
    rx_ready = 1'b0;
    rx_rst   = 1'b0;
  endtask

  task automatic frame(input logic [7:0] d, input logic stop, input int mode,
                       input int rst_at, input int hold);
    logic r;
    send_frame(d, stop, mode, rst_at, hold);
    r = (mode != 0);
    if (rst_at >= 0) begin
      model_v = 1'b0;
      model_d = 8'h00;
    end else begin
      if (mode == 1) model_v = 1'b0;
      if (stop) begin
        if (!model_v || r) begin
          model_d = d;
          model_v = 1'b1;
        end else model_ov++;
      end else begin
        model_fe++;
        if (r) model_v = 1'b0;
      end
      if (mode == 1) model_v = 1'b0;
    end
  endtask

  typedef struct {
    logic [7:0] d;
    logic       stop;
    int         mode;
    int         hold;
    logic       pre;
    logic [7:0] xd;
    logic       xv;
    int         xe, xo, xr, xf, xw;
  } vec_t;

  initial begin
    vec_t tbl[6];
    int r0, f0, e0, o0, lat;
    logic [7:0] rd;
    logic rs;
    int rm;
    //            d     stp md hold  pre  xd    xv xe xo xr xf xw
    tbl[0] = '{8'h54, 1'b1, 1, 0,    1'b0, 8'h54, 1'b0, 0, 0, 1, 1, 1};
    tbl[1] = '{8'hA5, 1'b0, 0, 2000, 1'b0, 8'h54, 1'b0, 1, 0, 0, 0, 0};
    tbl[2] = '{8'h11, 1'b1, 0, 0,    1'b0, 8'h11, 1'b1, 0, 0, 1, 0, 0};
    tbl[3] = '{8'h22, 1'b1, 0, 0,    1'b0, 8'h11, 1'b1, 0, 1, 0, 0, 0};
    tbl[4] = '{8'h11, 1'b1, 0, 0,    1'b1, 8'h11, 1'b1, 0, 0, 1, 0, 0};
    tbl[5] = '{8'h22, 1'b1, 2, 0,    1'b0, 8'h22, 1'b1, 0, 0, 0, 0, 0};

    rx_rst = 1'b1;
    idle(3);
    chk("reset data", 32'(rx_data), 0);
    chk("reset valid", 32'(rx_valid), 0);
    chk("reset ferr", 32'(rx_frame_err), 0);
    chk("reset ovr", 32'(rx_overrun), 0);
    chk("reset busy", 32'(rx_busy), 0);
    rx_rst = 1'b0;
    idle(4);

    for (int t = 0; t < 6; t++) begin
      if (tbl[t].pre) begin
        pulse_ready();
        chk($sformatf("t%0d consume valid", t), 32'(rx_valid), 0);
      end
      r0 = rise_cnt; f0 = fall_cnt; e0 = ferr_seen; o0 = ovr_seen;
      frame(tbl[t].d, tbl[t].stop, tbl[t].mode, -1, tbl[t].hold);
      idle(8);
      chk($sformatf("t%0d data", t), 32'(rx_data), 32'(tbl[t].xd));
      chk($sformatf("t%0d valid", t), 32'(rx_valid), 32'(tbl[t].xv));
      chk($sformatf("t%0d busy", t), 32'(rx_busy), 0);
      chk($sformatf("t%0d ferr pulses", t), ferr_seen - e0, tbl[t].xe);
      chk($sformatf("t%0d ovr pulses", t), ovr_seen - o0, tbl[t].xo);
      chk($sformatf("t%0d valid rises", t), rise_cnt - r0, tbl[t].xr);
      chk($sformatf("t%0d valid falls", t), fall_cnt - f0, tbl[t].xf);
      if (tbl[t].xw != 0) chk($sformatf("t%0d valid width", t), last_vw, tbl[t].xw);
    end

    // glitch shorter than half a bit, then a real frame with latency check
    pulse_ready();
    r0 = rise_cnt; e0 = ferr_seen;
    rx_input = 1'b0;
    idle(50);
    chk("glitch busy", 32'(rx_busy), 1);
    idle(50);
    rx_input = 1'b1;
    idle(C);
    chk("glitch idle", 32'(rx_busy), 0);
    chk("glitch valid", 32'(rx_valid), 0);
    chk("glitch ferr", ferr_seen - e0, 0);
    chk("glitch rises", rise_cnt - r0, 0);
    frame(8'h3C, 1'b1, 0, -1, 0);
    idle(8);
    chk("3C data", 32'(rx_data), 32'h3C);
    chk("3C valid", 32'(rx_valid), 1);
    lat = rise_cyc - fall_cyc;
    vec_cnt++;
    if (lat < L - 1 || lat > L + 1) begin
      bad_cnt++;
      $display("FAIL latency: got %0d cycles expected %0d +/-1", lat, L);
    end

    // reset during data bit 3, then a clean frame
    pulse_ready();
    r0 = rise_cnt; e0 = ferr_seen; o0 = ovr_seen;
    frame(8'hC3, 1'b1, 0, 4 * C + C / 2, 0);
    idle(C);
    chk("abort valid", 32'(rx_valid), 0);
    chk("abort busy", 32'(rx_busy), 0);
    chk("abort rises", rise_cnt - r0, 0);
    chk("abort flags", (ferr_seen - e0) + (ovr_seen - o0), 0);
    frame(8'hC3, 1'b1, 0, -1, 0);
    idle(8);
    chk("C3 data", 32'(rx_data), 32'hC3);
    chk("C3 valid", 32'(rx_valid), 1);

    // random frames against the model
    model_fe = ferr_seen;
    model_ov = ovr_seen;
    for (int n = 0; n < 5; n++) begin
      if ($urandom_range(1, 0) == 1) pulse_ready();
      rd = 8'($urandom);
      rs = ($urandom_range(3, 0) != 0);
      rm = int'($urandom_range(2, 0));
      frame(rd, rs, rm, -1, 0);
      idle(8);
      chk($sformatf("rnd%0d data", n), 32'(rx_data), 32'(model_d));
      chk($sformatf("rnd%0d valid", n), 32'(rx_valid), 32'(model_v));
      chk($sformatf("rnd%0d ferr total", n), ferr_seen, model_fe);
      chk($sformatf("rnd%0d ovr total", n), ovr_seen, model_ov);
    end

    chk("flags exclusive", both_seen, 0);
    chk("flag single cycle", wide_seen, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, bad_cnt);
    $finish;
  end
endmodule
